axil_sram_slave: RTL and testbench

- AXI4-Lite slave terminating the OCL BAR path downstream of the AXI-Lite register slice, backed by an on-chip single-port byte-writable SRAM.
- Captures AW/W/AR into holding registers and arbitrates round-robin between pending writes and reads.
- Addresses outside the RAM window return SLVERR; the RAM is not touched for those.
- Single clock `clk`; reset `reset` is asynchronous and active-high.

---
 rtl/axil_sram_pkg.sv | 15 +
 rtl/sp_ram_be.sv | 30 +++
 rtl/axil_sram_slave.sv | 210 +++++++++++++++++++++
 tb/tb_axil_sram_slave.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_sram_pkg.sv
// Shared definitions for the AXI4-Lite SRAM slave: response codes and FSM states.
package axil_sram_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BRESP = 2'd1,
        ST_RD    = 2'd2,
        ST_RRESP = 2'd3
    } axil_state_e;

endpackage

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables,
// one-cycle registered read. No reset so it maps onto block RAM.
module sp_ram_be #(
    parameter int addr_bits = 12
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [3:0]           we,
    input  logic [addr_bits-3:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 2 ** (addr_bits - 2);

    logic [31:0] mem [0:DEPTH-1];

    // Byte-masked write and registered read on the same port.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave backed by a byte-writable single-port SRAM.
// Handshake rule on every channel: a beat transfers on the rising clk edge
// where valid and ready are both high; a source keeps valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
// AW, W and AR each land in a one-deep holding slot; a round-robin sequencer
// then serialises writes and reads onto the single RAM port.
module axil_sram_slave
    import axil_sram_pkg::*;
#(
    parameter int addr_bits = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        axi_awvalid,
    input  logic [31:0] axi_awaddr,
    output logic        axi_awready,
    input  logic        axi_wvalid,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_wready,
    output logic        axi_bvalid,
    output logic [1:0]  axi_bresp,
    input  logic        axi_bready,
    input  logic        axi_arvalid,
    input  logic [31:0] axi_araddr,
    output logic        axi_arready,
    output logic        axi_rvalid,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    input  logic        axi_rready
);

    localparam int IDX_W = addr_bits - 2;

    // Sequencer state, kept as a named internal signal so checkers can bind to it.
    axil_state_e state;
    axil_state_e state_next;

    logic             run;
    logic             aw_full, w_full, ar_full;
    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic             aw_ok, ar_ok, rd_ok;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic             last_wr;
    logic             grant_wr, grant_rd, b_done, r_done, rd_capture;
    logic             ram_en;
    logic [3:0]       ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_rdata;
    logic             aw_hs, w_hs, ar_hs;

    // Byte-lane offset bits carry no meaning for word-wide accesses.
    logic unused_lsbs;
    assign unused_lsbs = ^{axi_awaddr[1:0], axi_araddr[1:0]};

    assign axi_awready = run & ~aw_full;
    assign axi_wready  = run & ~w_full;
    assign axi_arready = run & ~ar_full;

    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid  & axi_wready;
    assign ar_hs = axi_arvalid & axi_arready;

    // Readies stay low until the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) run <= 1'b0;
        else       run <= 1'b1;
    end

    // Write-address slot: captured on handshake, freed when B completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_full <= 1'b0;
            aw_idx  <= '0;
            aw_ok   <= 1'b0;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= axi_awaddr[addr_bits-1:2];
            aw_ok   <= (axi_awaddr[31:addr_bits] == '0);
        end else if (b_done) begin
            aw_full <= 1'b0;
        end
    end

    // Write-data slot: captured on handshake, freed when B completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_full <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (w_hs) begin
            w_full <= 1'b1;
            w_data <= axi_wdata;
            w_strb <= axi_wstrb;
        end else if (b_done) begin
            w_full <= 1'b0;
        end
    end

    // Read-address slot: captured on handshake, freed when R completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_full <= 1'b0;
            ar_idx  <= '0;
            ar_ok   <= 1'b0;
        end else if (ar_hs) begin
            ar_full <= 1'b1;
            ar_idx  <= axi_araddr[addr_bits-1:2];
            ar_ok   <= (axi_araddr[31:addr_bits] == '0);
        end else if (r_done) begin
            ar_full <= 1'b0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state and grant decisions; on a tie the type not granted last wins.
    always_comb begin
        state_next = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        b_done     = 1'b0;
        r_done     = 1'b0;
        rd_capture = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (aw_full && w_full && (!ar_full || !last_wr)) begin
                    grant_wr   = 1'b1;
                    state_next = ST_BRESP;
                end else if (ar_full) begin
                    grant_rd   = 1'b1;
                    state_next = ST_RD;
                end
            end
            ST_BRESP: begin
                if (axi_bvalid && axi_bready) begin
                    b_done     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_RD: begin
                rd_capture = 1'b1;
                state_next = ST_RRESP;
            end
            ST_RRESP: begin
                if (axi_rvalid && axi_rready) begin
                    r_done     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Single RAM port: the write commits on its grant edge, reads are issued on theirs.
    always_comb begin
        ram_en   = grant_wr | grant_rd;
        ram_addr = grant_rd ? ar_idx : aw_idx;
        ram_we   = (grant_wr && aw_ok) ? w_strb : 4'b0000;
    end

    sp_ram_be #(
        .addr_bits (addr_bits)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (w_data),
        .rdata (ram_rdata)
    );

    // Response channels, range flag for the read in flight, and round-robin memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            axi_bvalid <= 1'b0;
            axi_bresp  <= AXI_RESP_OKAY;
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
            axi_rresp  <= AXI_RESP_OKAY;
            rd_ok      <= 1'b0;
            last_wr    <= 1'b0;
        end else begin
            if (grant_wr) begin
                axi_bvalid <= 1'b1;
                axi_bresp  <= aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                last_wr    <= 1'b1;
            end else if (b_done) begin
                axi_bvalid <= 1'b0;
            end
            if (grant_rd) begin
                rd_ok   <= ar_ok;
                last_wr <= 1'b0;
            end
            if (rd_capture) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= rd_ok ? ram_rdata : 32'h0;
                axi_rresp  <= rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else if (r_done) begin
                axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed bench for axil_sram_slave with a response scoreboard and a word-level
// reference memory. Drives inputs #1 after posedge, samples on negedge.
module tb_axil_sram_slave;

    localparam int TMO = 50;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk;
    logic        reset;
    logic        axi_awvalid;
    logic [31:0] axi_awaddr;
    logic        axi_awready;
    logic        axi_wvalid;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wready;
    logic        axi_bvalid;
    logic [1:0]  axi_bresp;
    logic        axi_bready;
    logic        axi_arvalid;
    logic [31:0] axi_araddr;
    logic        axi_arready;
    logic        axi_rvalid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rready;

    int errors = 0;
    int checks = 0;

    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];
    logic [31:0] model_mem [0:1023];

    axil_sram_slave #(.addr_bits(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .axi_awvalid (axi_awvalid),
        .axi_awaddr  (axi_awaddr),
        .axi_awready (axi_awready),
        .axi_wvalid  (axi_wvalid),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wready  (axi_wready),
        .axi_bvalid  (axi_bvalid),
        .axi_bresp   (axi_bresp),
        .axi_bready  (axi_bready),
        .axi_arvalid (axi_arvalid),
        .axi_araddr  (axi_araddr),
        .axi_arready (axi_arready),
        .axi_rvalid  (axi_rvalid),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rready  (axi_rready)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=timeout expected=handshake within %0d cycles", tag, TMO);
    endtask

    // Scoreboard producers: update reference memory and queue expected responses.
    task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[31:12] == 20'h0) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
            exp_b_q.push_back(OKAY);
        end else begin
            exp_b_q.push_back(SLVERR);
        end
    endtask

    task automatic exp_read(input logic [31:0] a);
        if (a[31:12] == 20'h0) exp_r_q.push_back({OKAY, model_mem[a[11:2]]});
        else                   exp_r_q.push_back({SLVERR, 32'h0});
    endtask

    // Channel drivers.
    task automatic do_aw(input logic [31:0] a);
        int n = 0;
        axi_awvalid = 1'b1; axi_awaddr = a;
        do begin @(negedge clk); n++; end while (!axi_awready && n < TMO);
        if (!axi_awready) begin timeout_fail("aw_hs"); axi_awvalid = 1'b0; return; end
        @(posedge clk); #1; axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        axi_wvalid = 1'b1; axi_wdata = d; axi_wstrb = s;
        do begin @(negedge clk); n++; end while (!axi_wready && n < TMO);
        if (!axi_wready) begin timeout_fail("w_hs"); axi_wvalid = 1'b0; return; end
        @(posedge clk); #1; axi_wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a);
        int n = 0;
        axi_arvalid = 1'b1; axi_araddr = a;
        do begin @(negedge clk); n++; end while (!axi_arready && n < TMO);
        if (!axi_arready) begin timeout_fail("ar_hs"); axi_arvalid = 1'b0; return; end
        @(posedge clk); #1; axi_arvalid = 1'b0;
    endtask

    // Scoreboard consumers: wait for a response, compare, then accept it.
    task automatic get_b(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!axi_bvalid && n < TMO);
        if (!axi_bvalid) begin timeout_fail({tag, "_bvalid"}); return; end
        if (exp_b_q.size() == 0) begin timeout_fail({tag, "_unexpected_b"}); end
        else check({tag, "_bresp"}, 64'(axi_bresp), 64'(exp_b_q.pop_front()));
        axi_bready = 1'b1;
        @(posedge clk); #1; axi_bready = 1'b0;
    endtask

    task automatic get_r(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!axi_rvalid && n < TMO);
        if (!axi_rvalid) begin timeout_fail({tag, "_rvalid"}); return; end
        if (exp_r_q.size() == 0) begin timeout_fail({tag, "_unexpected_r"}); end
        else check({tag, "_rresp_rdata"}, 64'({axi_rresp, axi_rdata}), 64'(exp_r_q.pop_front()));
        axi_rready = 1'b1;
        @(posedge clk); #1; axi_rready = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        exp_write(a, d, s);
        fork
            do_aw(a);
            do_w(d, s);
        join
        get_b(tag);
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        exp_read(a);
        do_ar(a);
        get_r(tag);
    endtask

    initial begin
        reset = 1'b1;
        axi_awvalid = 1'b0; axi_awaddr = '0;
        axi_wvalid  = 1'b0; axi_wdata  = '0; axi_wstrb = '0;
        axi_bready  = 1'b0;
        axi_arvalid = 1'b0; axi_araddr = '0;
        axi_rready  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs",
              64'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid,
                   axi_bresp, axi_rresp, axi_rdata}), 64'h0);
        reset = 1'b0;
        #1;
        check("rst_ready_before_edge", 64'({axi_awready, axi_wready, axi_arready}), 64'h0);
        @(posedge clk); #1;
        check("rst_ready_after_edge", 64'({axi_awready, axi_wready, axi_arready}), 64'h7);

        // Simultaneous AW, W, AR straight out of reset: write wins
        model_mem[4] = 32'h0;
        exp_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        exp_read(32'h10);
        fork
            do_aw(32'h10);
            do_w(32'hDEAD_BEEF, 4'hF);
            do_ar(32'h10);
        join
        @(negedge clk);
        check("arb0_idle_cycle", 64'({axi_bvalid, axi_rvalid}), 64'h0);
        @(negedge clk);
        check("arb0_write_first", 64'({axi_bvalid, axi_rvalid}), 64'h2);
        get_b("arb0");
        get_r("arb0");

        // Full write then read with latency measurement
        exp_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        fork
            do_aw(32'h10);
            do_w(32'hDEAD_BEEF, 4'hF);
        join
        @(negedge clk);
        check("b_lat_edge0", 64'(axi_bvalid), 64'h0);
        @(negedge clk);
        check("b_lat_edge1", 64'(axi_bvalid), 64'h1);
        get_b("t1_wr");
        exp_read(32'h10);
        do_ar(32'h10);
        @(negedge clk);
        check("r_lat_edge0", 64'(axi_rvalid), 64'h0);
        @(negedge clk);
        check("r_lat_edge1", 64'(axi_rvalid), 64'h0);
        @(negedge clk);
        check("r_lat_edge2", 64'(axi_rvalid), 64'h1);
        get_r("t1_rd");
        rd(32'h13, "t1_rd_lsb_ignored");

        // Partial strobes and empty strobe
        wr(32'h20, 32'h1111_1111, 4'hF, "t2_prefill");
        wr(32'h20, 32'hAABB_CCDD, 4'h5, "t2_strb5");
        check("t2_model_merge", 64'(model_mem[8]), 64'h11BB_11DD);
        rd(32'h20, "t2_rd");
        wr(32'h20, 32'hFFFF_FFFF, 4'h0, "t2_strb0");
        rd(32'h20, "t2_rd_after_strb0");

        // Out-of-range accesses
        wr(32'h0, 32'h1234_5678, 4'hF, "t3_prefill0");
        wr(32'h1000, 32'h5, 4'hF, "t3_oor_wr");
        rd(32'h1000, "t3_oor_rd");
        rd(32'hF000_0004, "t3_oor_rd_high");
        rd(32'h0, "t3_word0_intact");

        // After a read grant, a simultaneous write+read goes to the write
        rd(32'h20, "t4_read_alone");
        exp_write(32'h30, 32'hCAFE_0001, 4'hF);
        exp_read(32'h30);
        fork
            do_aw(32'h30);
            do_w(32'hCAFE_0001, 4'hF);
            do_ar(32'h30);
        join
        @(negedge clk);
        @(negedge clk);
        check("arb1_write_first", 64'({axi_bvalid, axi_rvalid}), 64'h2);
        get_b("arb1");
        get_r("arb1");

        // W early, then AW+AR together; both responses held under backpressure
        exp_write(32'h40, 32'h0BAD_F00D, 4'hF);
        exp_read(32'h40);
        do_w(32'h0BAD_F00D, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        fork
            do_aw(32'h40);
            do_ar(32'h40);
        join
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!axi_bvalid && n < TMO);
            if (!axi_bvalid) timeout_fail("t5_bvalid");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_b_hold", 64'({axi_bvalid, axi_bresp, axi_rvalid, axi_awready, axi_wready}),
                  64'({1'b1, exp_b_q[0], 1'b0, 1'b0, 1'b0}));
        end
        get_b("t5");
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!axi_rvalid && n < TMO);
            if (!axi_rvalid) timeout_fail("t5_rvalid");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_r_hold", 64'({axi_rvalid, axi_arready, axi_rresp, axi_rdata}),
                  64'({1'b1, 1'b0, exp_r_q[0]}));
        end
        get_r("t5");

        // Randomised write/read pairs over a prefilled window, with some out of range
        for (int i = 0; i < 8; i++) wr(32'h100 + 32'(i * 4), $urandom, 4'hF, "rnd_prefill");
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = 32'h100 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 3) == 0) a = a | 32'h0002_0000;
            wr(a, $urandom, 4'($urandom_range(0, 15)), "rnd_wr");
            rd(a & 32'h0000_0FFF, "rnd_rd");
        end

        // Reset while a write response is pending
        exp_write(32'h50, 32'h7777_8888, 4'hF);
        fork
            do_aw(32'h50);
            do_w(32'h7777_8888, 4'hF);
        join
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!axi_bvalid && n < TMO);
            if (!axi_bvalid) timeout_fail("t6_bvalid");
        end
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_clear", 64'({axi_bvalid, axi_awready, axi_wready, axi_arready}), 64'h0);
        exp_b_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_ready_low_after_release", 64'({axi_awready, axi_wready, axi_arready}), 64'h0);
        @(posedge clk); #1;
        check("t6_ready_high_after_edge", 64'({axi_awready, axi_wready, axi_arready}), 64'h7);
        rd(32'h50, "t6_committed_before_reset");
        wr(32'h54, 32'h1357_9BDF, 4'hF, "t6_wr_after");
        rd(32'h54, "t6_rd_after");

        check("sb_b_drained", 64'(exp_b_q.size()), 64'h0);
        check("sb_r_drained", 64'(exp_r_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
